// File: rtl/nand_rb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_rb_pkg
// Description : Shared constants for the NAND ready/busy supervisor: event
//               codes reported to the scheduler and per-chip FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_rb_pkg;

    // Event codes carried on evt_code
    localparam logic [1:0] EVT_READY   = 2'd0;
    localparam logic [1:0] EVT_TIMEOUT = 2'd1;
    localparam logic [1:0] EVT_NOBUSY  = 2'd2;

    // Per-chip supervision state
    typedef logic [1:0] rb_state_t;
    localparam rb_state_t ST_IDLE      = 2'd0;
    localparam rb_state_t ST_WAIT_BUSY = 2'd1;
    localparam rb_state_t ST_BUSY      = 2'd2;
    localparam rb_state_t ST_DONE      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/nand_rb_filter.sv
`default_nettype none
// ============================================================================
// Module      : nand_rb_filter
// Description : Synchronizer and glitch filter for one open-drain R/B# line.
//               The filtered level only follows the synchronized pin once it
//               has disagreed for FILT_CYCLES consecutive samples.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_rb_filter
    import nand_rb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rb_n_raw,
    output logic busy
);

    localparam int               c_RUN_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [c_RUN_W-1:0]     r_run;
    logic                   w_sync_out;

    // Metastability chain; idles high because the line is pulled up when ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= rb_n_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Run-length filter: any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_run   <= '0;
        end else if (w_sync_out == r_level) begin
            r_run <= '0;
        end else if (r_run == c_RUN_MAX) begin
            r_level <= w_sync_out;
            r_run   <= '0;
        end else begin
            r_run <= r_run + c_RUN_W'(1);
        end
    end

    assign busy = ~r_level;

endmodule
`default_nettype wire

// File: rtl/nand_rb_monitor.sv
`default_nettype none
// ============================================================================
// Module      : nand_rb_monitor
// Description : Per-chip R/B# supervisor. Filters each line, tracks armed busy
//               operations, and reports READY / TIMEOUT / NOBUSY events
//               through a round-robin arbiter and a registered valid/ready
//               output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_rb_monitor
    import nand_rb_pkg::*;
#(
    parameter int NUM_CHIPS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int TWB_CYCLES  = 64,
    parameter int CNT_W       = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CHIPS-1:0]          rb_n_in,
    input  logic                          arm_valid,
    input  logic [$clog2(NUM_CHIPS)-1:0]  arm_chip,
    input  logic [CNT_W-1:0]              arm_timeout,
    output logic                          arm_ready,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(NUM_CHIPS)-1:0]  evt_chip,
    output logic [1:0]                    evt_code,
    output logic [CNT_W-1:0]              evt_cycles,
    output logic [NUM_CHIPS-1:0]          rb_busy
);

    localparam int               c_CHIP_W = $clog2(NUM_CHIPS);
    localparam logic [CNT_W-1:0] c_TWB    = CNT_W'(TWB_CYCLES);

    rb_state_t          r_state    [NUM_CHIPS];
    rb_state_t          w_state_nxt[NUM_CHIPS];
    logic [CNT_W-1:0]   r_cnt      [NUM_CHIPS];
    logic [CNT_W-1:0]   w_cnt_nxt  [NUM_CHIPS];
    logic [CNT_W-1:0]   r_tmo      [NUM_CHIPS];
    logic [CNT_W-1:0]   w_tmo_nxt  [NUM_CHIPS];
    logic [1:0]         r_code     [NUM_CHIPS];
    logic [1:0]         w_code_nxt [NUM_CHIPS];

    logic [NUM_CHIPS-1:0] w_done;
    logic [c_CHIP_W-1:0]  r_ptr;
    logic [c_CHIP_W-1:0]  w_gnt_idx;
    logic                 w_gnt_vld;
    logic                 w_load;
    logic                 w_take;
    logic                 w_arm_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHIPS; gi++) begin : g_filter
            nand_rb_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_CYCLES (FILT_CYCLES)
            ) u_filter (
                .clk      (clk),
                .rst_n    (rst_n),
                .rb_n_raw (rb_n_in[gi]),
                .busy     (rb_busy[gi])
            );
        end
    endgenerate

    // Arm acceptance depends only on the addressed chip being idle
    always_comb begin
        arm_ready = 1'b0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (arm_chip == c_CHIP_W'(i) && r_state[i] == ST_IDLE) begin
                arm_ready = 1'b1;
            end
        end
    end

    assign w_arm_fire = arm_valid && arm_ready;

    // Round-robin search over DONE chips starting at the pointer
    always_comb begin
        int                  v_j;
        logic [c_CHIP_W-1:0] v_idx;
        v_j       = 0;
        v_idx     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_done[i] = (r_state[i] == ST_DONE);
        end
        for (int k = 0; k < NUM_CHIPS; k++) begin
            v_j = int'(r_ptr) + k;
            if (v_j >= NUM_CHIPS) begin
                v_j = v_j - NUM_CHIPS;
            end
            v_idx = c_CHIP_W'(v_j);
            if (!w_gnt_vld && w_done[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    // Output slot frees when empty or drained this cycle
    assign w_load = !evt_valid || evt_ready;
    assign w_take = w_load && w_gnt_vld;

    // Per-chip next state; counter runs in WAIT_BUSY/BUSY and freezes in DONE
    always_comb begin
        logic [CNT_W-1:0] v_inc;
        v_inc = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_tmo_nxt[i]   = r_tmo[i];
            w_code_nxt[i]  = r_code[i];
            v_inc          = (&r_cnt[i]) ? r_cnt[i] : r_cnt[i] + CNT_W'(1);
            case (r_state[i])
                ST_IDLE: begin
                    if (w_arm_fire && arm_chip == c_CHIP_W'(i)) begin
                        w_state_nxt[i] = ST_WAIT_BUSY;
                        w_cnt_nxt[i]   = '0;
                        w_tmo_nxt[i]   = arm_timeout;
                    end
                end
                ST_WAIT_BUSY: begin
                    w_cnt_nxt[i] = v_inc;
                    // Busy seen on the last tWB cycle still counts as busy
                    if (rb_busy[i]) begin
                        w_state_nxt[i] = ST_BUSY;
                    end else if (v_inc == c_TWB) begin
                        w_state_nxt[i] = ST_DONE;
                        w_code_nxt[i]  = EVT_NOBUSY;
                    end
                end
                ST_BUSY: begin
                    w_cnt_nxt[i] = v_inc;
                    // A chip that finished on the timeout cycle is reported ready
                    if (!rb_busy[i]) begin
                        w_state_nxt[i] = ST_DONE;
                        w_code_nxt[i]  = EVT_READY;
                    end else if (r_tmo[i] != '0 && v_inc == r_tmo[i]) begin
                        w_state_nxt[i] = ST_DONE;
                        w_code_nxt[i]  = EVT_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    if (w_take && w_gnt_idx == c_CHIP_W'(i)) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Per-chip state, counter, timeout and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHIPS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_tmo[i]   <= '0;
                r_code[i]  <= EVT_READY;
            end
        end else begin
            for (int i = 0; i < NUM_CHIPS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_tmo[i]   <= w_tmo_nxt[i];
                r_code[i]  <= w_code_nxt[i];
            end
        end
    end

    // Event output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_chip   <= '0;
            evt_code   <= EVT_READY;
            evt_cycles <= '0;
            r_ptr      <= '0;
        end else if (w_load) begin
            evt_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                evt_chip   <= w_gnt_idx;
                evt_code   <= r_code[w_gnt_idx];
                evt_cycles <= r_cnt[w_gnt_idx];
                r_ptr      <= (w_gnt_idx == c_CHIP_W'(NUM_CHIPS - 1)) ? '0
                                                                       : w_gnt_idx + c_CHIP_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nand_rb_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_rb_monitor
// Description : Self-checking bench for nand_rb_monitor: table of single-chip
//               scenarios plus hand sequences for glitches, arm stalling,
//               reset mid-flight and simultaneous completion with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_rb_monitor;
    import nand_rb_pkg::*;

    localparam int NUM_CHIPS = 4;
    localparam int CNT_W     = 24;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_CHIPS-1:0] rb_n_in = '1;
    logic                 arm_valid = 1'b0;
    logic [1:0]           arm_chip = '0;
    logic [CNT_W-1:0]     arm_timeout = '0;
    logic                 arm_ready;
    logic                 evt_valid;
    logic                 evt_ready = 1'b1;
    logic [1:0]           evt_chip;
    logic [1:0]           evt_code;
    logic [CNT_W-1:0]     evt_cycles;
    logic [NUM_CHIPS-1:0] rb_busy;

    nand_rb_monitor #(
        .NUM_CHIPS   (NUM_CHIPS),
        .SYNC_STAGES (2),
        .FILT_CYCLES (4),
        .TWB_CYCLES  (64),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rb_n_in     (rb_n_in),
        .arm_valid   (arm_valid),
        .arm_chip    (arm_chip),
        .arm_timeout (arm_timeout),
        .arm_ready   (arm_ready),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chip    (evt_chip),
        .evt_code    (evt_code),
        .evt_cycles  (evt_cycles),
        .rb_busy     (rb_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int chip;
        int code;
        int cycles;
    } evt_t;

    typedef struct {
        int chip;
        int tmo;
        int low_at;   // offset after arm edge where pin goes low, -1 = never
        int high_at;  // offset where pin returns high, -1 = after the event
        int code;
        int cycles;
    } vec_t;

    evt_t sb[$];
    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard check on a handshake that will complete at the next edge
    task automatic check_evt();
        evt_t e;
        if (rst_n && evt_valid && evt_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL evt_unexpected: actual chip=%0d code=%0d cycles=%0d required no event",
                         evt_chip, evt_code, evt_cycles);
            end else begin
                e = sb.pop_front();
                if (int'(evt_chip) != e.chip || int'(evt_code) != e.code ||
                    int'(evt_cycles) != e.cycles) begin
                    n_err++;
                    $display("FAIL evt_match: actual chip=%0d code=%0d cycles=%0d required chip=%0d code=%0d cycles=%0d",
                             evt_chip, evt_code, evt_cycles, e.chip, e.code, e.cycles);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_evt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: actual pending=%0d required pending=0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int      t;
        int      x;
        int      a_cyc[NUM_CHIPS];
        int      n_seen;
        vec_t    v;

        vecs[0] = '{1,   0, 10, 500, EVT_READY,   507};
        vecs[1] = '{0,   0, -1,  -1, EVT_NOBUSY,   64};
        vecs[2] = '{2, 200, 10,  -1, EVT_TIMEOUT, 200};
        vecs[3] = '{3,   0,  5,  35, EVT_READY,    42};
        vecs[4] = '{0, 100,  3,  53, EVT_READY,    60};
        vecs[5] = '{1,   0, 57,  90, EVT_READY,    97};  // busy on last tWB cycle
        vecs[6] = '{2,   0, 58,  -1, EVT_NOBUSY,   64};  // busy one cycle too late
        vecs[7] = '{3, 200, 10, 193, EVT_READY,   200};  // ready ties with timeout
        vecs[8] = '{0, 200, 10, 194, EVT_TIMEOUT, 200};

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_arm_ready", arm_ready, 1);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_chip", evt_chip, 0);
        chk("rst_evt_code", evt_code, 0);
        chk("rst_evt_cycles", evt_cycles, 0);
        chk("rst_rb_busy", rb_busy, 0);

        // Table of single-chip scenarios
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            arm_chip    = 2'(v.chip);
            arm_timeout = CNT_W'(v.tmo);
            arm_valid   = 1'b1;
            sb.push_back('{v.chip, v.code, v.cycles});
            tick();
            arm_valid = 1'b0;
            t = 0;
            while (sb.size() != 0 && t < 2000) begin
                if (t == v.low_at)  rb_n_in[v.chip] = 1'b0;
                if (t == v.high_at) rb_n_in[v.chip] = 1'b1;
                if (v.low_at >= 0 && t == v.low_at + 5) chk("vec_rb_busy_lag", rb_busy[v.chip], 0);
                if (v.low_at >= 0 && t == v.low_at + 6) chk("vec_rb_busy_on", rb_busy[v.chip], 1);
                if (t == 1) chk("vec_arm_ready_armed", arm_ready, 0);
                tick();
                t++;
            end
            if (sb.size() != 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL vec%0d_timeout: actual pending=%0d required pending=0", i, sb.size());
                sb.delete();
            end
            rb_n_in[v.chip] = 1'b1;
            repeat (10) tick();
            chk("vec_rb_busy_idle", rb_busy[v.chip], 0);
            chk("vec_arm_ready_idle", arm_ready, 1);
        end

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        arm_chip    = 2'd3;
        arm_timeout = '0;
        arm_valid   = 1'b1;
        sb.push_back('{3, EVT_READY, 26});
        tick();
        arm_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            if (t == 2)  rb_n_in[3] = 1'b0;
            if (t == 5)  rb_n_in[3] = 1'b1;
            if (t == 15) rb_n_in[3] = 1'b0;
            if (t == 19) rb_n_in[3] = 1'b1;
            if (t >= 3 && t <= 14) chk("glitch_rb_busy_low", rb_busy[3], 0);
            if (t == 14) chk("glitch_arm_ready", arm_ready, 0);
            if (t == 21) chk("glitch_rb_busy_seen", rb_busy[3], 1);
            tick();
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL glitch_timeout: actual pending=%0d required pending=0", sb.size());
            sb.delete();
        end
        repeat (10) tick();

        // Arm to a non-idle chip stalls, then lands right after DONE->IDLE
        arm_chip    = 2'd2;
        arm_timeout = '0;
        arm_valid   = 1'b1;
        sb.push_back('{2, EVT_NOBUSY, 64});
        sb.push_back('{2, EVT_NOBUSY, 64});
        tick();
        for (t = 0; t < 66; t++) begin
            if (t == 1)  chk("stall_arm_ready_wait", arm_ready, 0);
            if (t == 64) chk("stall_arm_ready_done", arm_ready, 0);
            if (t == 65) chk("stall_arm_ready_free", arm_ready, 1);
            tick();
        end
        arm_valid = 1'b0;
        chk("stall_rearmed", arm_ready, 0);
        drain("stall", 300);
        repeat (5) tick();

        // Reset while chips 0/1 busy and an event is pending
        evt_ready   = 1'b0;
        arm_timeout = '0;
        arm_valid   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            arm_chip = 2'(c);
            tick();
        end
        arm_valid  = 1'b0;
        rb_n_in[0] = 1'b0;
        rb_n_in[1] = 1'b0;
        repeat (80) tick();
        chk("rst_mid_evt_pending", evt_valid, 1);
        chk("rst_mid_evt_chip", evt_chip, 2);
        chk("rst_mid_rb_busy", rb_busy, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_evt_valid_async", evt_valid, 0);
        chk("rst_mid_rb_busy_async", rb_busy, 0);
        rb_n_in = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < NUM_CHIPS; c++) begin
            arm_chip = 2'(c);
            #1;
            chk("rst_mid_arm_ready", arm_ready, 1);
            tick();
        end
        evt_ready = 1'b1;
        n_seen = 0;
        repeat (100) begin
            if (evt_valid) n_seen++;
            tick();
        end
        chk("rst_mid_no_stale_evt", n_seen, 0);

        // All four chips complete together under backpressure
        evt_ready   = 1'b0;
        arm_timeout = '0;
        arm_valid   = 1'b1;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            arm_chip = 2'(c);
            tick();
            a_cyc[c] = cyc;
        end
        arm_valid = 1'b0;
        rb_n_in   = '0;
        repeat (20) tick();
        chk("all_rb_busy", rb_busy, 4'b1111);
        x       = cyc;
        rb_n_in = '1;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            sb.push_back('{c, EVT_READY, x + 7 - a_cyc[c]});
        end
        repeat (8) tick();
        for (int k = 0; k < 20; k++) begin
            chk("hold_evt_valid", evt_valid, 1);
            chk("hold_evt_chip", evt_chip, 0);
            chk("hold_evt_code", evt_code, EVT_READY);
            chk("hold_evt_cycles", evt_cycles, x + 7 - a_cyc[0]);
            tick();
        end
        evt_ready = 1'b1;
        for (int k = 0; k < NUM_CHIPS; k++) begin
            chk("b2b_evt_valid", evt_valid, 1);
            tick();
        end
        chk("b2b_evt_empty", evt_valid, 0);
        chk("b2b_sb_empty", sb.size(), 0);
        drain("final", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nand_rb_monitor.md
# nand_rb_monitor

Ready/busy supervisor sitting between the NAND package R/B# pins (Rb_n..Rb4_n) and the flash controller's command scheduler. Synchronizes and glitch-filters each chip's open-drain R/B# line, tracks per-chip busy operations armed by the scheduler, and reports completion, missing-busy or timeout as events over a valid/ready channel. Lets the scheduler issue to other chips without polling status (70h).

## Interface
- NUM_CHIPS, 4, number of R/B# lines / chip enables supervised
- SYNC_STAGES, 2, synchronizer flops per line
- FILT_CYCLES, 4, consecutive stable samples required to change filtered level
- TWB_CYCLES, 64, max cycles after arm for busy to appear (tWB window)
- CNT_W, 24, width of busy-duration counter and timeout value

- CLK  in  1  system clock; one clock domain
- RST_N  in  1  reset, asynchronous, active-low
- rb_n_in  in  NUM_CHIPS  raw R/B# pins, asynchronous, 0 = busy
- arm_valid  in  1  scheduler requests supervision of arm_chip
- arm_chip  in  $clog2(NUM_CHIPS)  chip index
- arm_timeout  in  CNT_W  busy timeout in cycles; 0 = no timeout
- arm_ready  out  1  addressed chip is IDLE
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_chip  out  $clog2(NUM_CHIPS)  chip that produced event
- evt_code  out  2  0 = READY, 1 = TIMEOUT, 2 = NOBUSY
- evt_cycles  out  CNT_W  cycles from arm to event (saturating)
- rb_busy  out  NUM_CHIPS  filtered busy status, 1 = busy

## Operation
- Filter per chip: SYNC_STAGES flop chain, then filtered level flips only after synchronized value differs from it for FILT_CYCLES consecutive cycles; any agreeing sample clears the run counter.
- Per-chip FSM: IDLE, WAIT_BUSY, BUSY, DONE.
- IDLE -> WAIT_BUSY on arm handshake (arm_valid && arm_ready); latch arm_timeout, clear counter.
- WAIT_BUSY -> BUSY when filtered busy; -> DONE code NOBUSY when counter reaches TWB_CYCLES first.
- BUSY -> DONE code READY when filtered ready; -> DONE code TIMEOUT when timeout != 0 and counter == timeout.
- Same cycle ready and timeout: READY wins. Same cycle busy and TWB expiry in WAIT_BUSY: BUSY wins.
- Counter increments every cycle in WAIT_BUSY/BUSY, saturates at all-ones, frozen in DONE.
- DONE -> IDLE when its event is loaded into the output register.
- Arbiter: round-robin over DONE chips, pointer reset to 0, after grant pointer = granted+1 mod NUM_CHIPS.
- Output register loads when empty or being consumed this cycle (evt_valid && evt_ready): one event per cycle sustained.
- arm_ready is combinational from arm_chip state; arm to a non-IDLE chip is stalled, never dropped.

## Timing
- Reset values: arm_ready reflects IDLE (1), evt_valid 0, evt_chip 0, evt_code 0, evt_cycles 0, rb_busy all 0 (filtered level resets to ready); all FSMs IDLE; pointer 0.
- Pin-to-rb_busy latency: SYNC_STAGES + FILT_CYCLES cycles (6 at defaults).
- FSM entering DONE at cycle N: evt_valid earliest at N+1 (registered output).
- evt_* stable while evt_valid && !evt_ready.
- Reset asserted mid-operation: all in-flight supervision discarded, no event emitted; pending output event lost.
- Re-arm of chip allowed in the cycle after its DONE -> IDLE transition.

## Structure
- Package nand_rb_pkg: evt code constants (EVT_READY, EVT_TIMEOUT, EVT_NOBUSY), FSM state encoding.
- Sub-module nand_rb_filter (synchronizer + glitch filter, one line), instantiated NUM_CHIPS times; FSMs, arbiter, output register in top.

## Test plan
- Arm chip 1, timeout 0; drive rb_n_in[1] low at +10, high at +500 -> one event chip 1, code READY, evt_cycles ≈ 500 + filter latency; rb_busy[1] tracked with 6-cycle lag.
- Arm chip 0, never drive busy -> event code NOBUSY at TWB_CYCLES (64) after arm.
- Arm chip 2, timeout 200, hold busy -> event code TIMEOUT, evt_cycles 200; chip returns IDLE, arm_ready 1.
- Glitch: 3-cycle low pulse on rb_n_in[3] while armed -> rb_busy[3] stays 0, no state change; 4-cycle pulse -> busy seen.
- All 4 chips finish same cycle, evt_ready held low 20 cycles then high -> first event held stable, then chips 0,1,2,3 delivered back-to-back in that order.
- Assert RST_N while chips 0 and 1 busy and event pending -> evt_valid 0 immediately, all arm_ready 1 after release, no stale events.
